// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch side (i_*), memory-stage side (d_*)
// and the shared downstream memory port (m_*).
// master: the arbiter's view. slave: the surrounding pipeline/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              i_valid;
  logic [ADDR_W-1:0] i_addr;
  logic              i_data_ok;
  logic [DATA_W-1:0] i_rdata;

  logic              d_valid;
  logic [ADDR_W-1:0] d_addr;
  logic [2:0]        d_size;
  logic [7:0]        d_strobe;
  logic [DATA_W-1:0] d_wdata;
  logic              d_data_ok;
  logic [DATA_W-1:0] d_rdata;

  logic              m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [2:0]        m_size;
  logic [7:0]        m_strobe;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ready;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    input  i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata,
    input  m_ready, m_rdata,
    output i_data_ok, i_rdata, d_data_ok, d_rdata,
    output m_valid, m_addr, m_size, m_strobe, m_wdata
  );

  modport slave (
    output i_valid, i_addr, d_valid, d_addr, d_size, d_strobe, d_wdata,
    output m_ready, m_rdata,
    input  i_data_ok, i_rdata, d_data_ok, d_rdata,
    input  m_valid, m_addr, m_size, m_strobe, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory port between instruction
// fetch (I) and the memory stage (D). One access at a time, grant held until
// m_ready, response routed only to the granted side. Includes a sticky
// watchdog for hung accesses (TIMEOUT_CYCLES = 0 disables it).
// Optional build macro MEM_PORT_ARBITER_RR_EN: alternate the grant when both
// sides request together; otherwise D always wins over I.
//
// state     | meaning
// ST_IDLE   | no access in flight, m_valid low, requests sampled here
// ST_BUSY_I | fetch access presented downstream, waiting for m_ready
// ST_BUSY_D | data access presented downstream, waiting for m_ready
module mem_port_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.master  bus,
  output logic                busy,
  output logic                err
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_BUSY_I = 2'b01;
  localparam logic [1:0] ST_BUSY_D = 2'b10;

  localparam logic [2:0] SIZE_WORD = 3'b011;

  localparam int              WD_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [2:0]        m_size_q, m_size_d;
  logic [7:0]        m_strobe_q, m_strobe_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [WD_W-1:0]   wd_q;
  logic              err_q;
  logic              pick_d;
  logic              enter_busy;
  logic              in_busy;

`ifdef MEM_PORT_ARBITER_RR_EN
  // last_grant_q: 1 = D was granted last, 0 = I (reset value)
  logic last_grant_q;

  // Contention goes to the side that did not win last time
  always_comb begin
    if (bus.d_valid && bus.i_valid) pick_d = ~last_grant_q;
    else                            pick_d = bus.d_valid;
  end

  // Remember which side took the port at every grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           last_grant_q <= 1'b0;
    else if (enter_busy) last_grant_q <= (state_d == ST_BUSY_D);
  end
`else
  // Fixed priority: the memory stage holds the older instruction
  always_comb begin
    pick_d = bus.d_valid;
  end
`endif

  // Next state and downstream payload capture at grant time
  always_comb begin
    state_d    = state_q;
    m_addr_d   = m_addr_q;
    m_size_d   = m_size_q;
    m_strobe_d = m_strobe_q;
    m_wdata_d  = m_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_d) begin
          state_d    = ST_BUSY_D;
          m_addr_d   = bus.d_addr;
          m_size_d   = bus.d_size;
          m_strobe_d = bus.d_strobe;
          m_wdata_d  = bus.d_wdata;
        end else if (bus.i_valid) begin
          state_d    = ST_BUSY_I;
          m_addr_d   = bus.i_addr;
          m_size_d   = SIZE_WORD;
          m_strobe_d = '0;
          m_wdata_d  = '0;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (bus.m_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and payload registers; reset abandons any in-flight access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      m_addr_q   <= '0;
      m_size_q   <= '0;
      m_strobe_q <= '0;
      m_wdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      m_addr_q   <= m_addr_d;
      m_size_q   <= m_size_d;
      m_strobe_q <= m_strobe_d;
      m_wdata_q  <= m_wdata_d;
    end
  end

  assign in_busy    = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
  assign enter_busy = (state_q == ST_IDLE) && (state_d != ST_IDLE);

  // Watchdog: down-counter loaded at grant, one tick per stalled busy cycle,
  // holds at zero; err latches when the count reaches terminal
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else if (enter_busy) begin
      wd_q <= WD_LOAD;
    end else if (in_busy && !bus.m_ready && (wd_q != '0)) begin
      wd_q <= wd_q - WD_ONE;
      if (wd_q == WD_ONE) err_q <= 1'b1;
    end
  end

  assign bus.m_valid  = in_busy;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_size   = m_size_q;
  assign bus.m_strobe = m_strobe_q;
  assign bus.m_wdata  = m_wdata_q;

  assign bus.i_data_ok = (state_q == ST_BUSY_I) && bus.m_ready;
  assign bus.d_data_ok = (state_q == ST_BUSY_D) && bus.m_ready;
  assign bus.i_rdata   = bus.i_data_ok ? bus.m_rdata : '0;
  assign bus.d_rdata   = bus.d_data_ok ? bus.m_rdata : '0;

  assign busy = in_busy;
  assign err  = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter (TIMEOUT_CYCLES = 8): directed vector table,
// hand-written reset/watchdog sequences, then random traffic against a
// transaction-level reference model.
module tb_mem_port_arbiter;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic busy, err;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus();

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        iv;  logic [63:0] ia;
    logic        dv;  logic [63:0] da; logic [2:0] dsz; logic [7:0] dstb; logic [63:0] dwd;
    logic        mr;  logic [63:0] mrd;
    logic        e_mv; logic [63:0] e_ma; logic [2:0] e_msz; logic [7:0] e_mstb; logic [63:0] e_mwd;
    logic        e_iok; logic e_dok;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [63:0] ia,
                       input logic dv, input logic [63:0] da, input logic [2:0] dsz,
                       input logic [7:0] dstb, input logic [63:0] dwd,
                       input logic mr, input logic [63:0] mrd);
    bus.i_valid  = iv;  bus.i_addr   = ia;
    bus.d_valid  = dv;  bus.d_addr   = da;  bus.d_size = dsz;
    bus.d_strobe = dstb; bus.d_wdata = dwd;
    bus.m_ready  = mr;  bus.m_rdata  = mrd;
  endtask

  function automatic void add(input logic iv, input logic [63:0] ia,
                              input logic dv, input logic [63:0] da, input logic [2:0] dsz,
                              input logic [7:0] dstb, input logic [63:0] dwd,
                              input logic mr, input logic [63:0] mrd,
                              input logic e_mv, input logic [63:0] e_ma, input logic [2:0] e_msz,
                              input logic [7:0] e_mstb, input logic [63:0] e_mwd,
                              input logic e_iok, input logic e_dok);
    vec_t v;
    v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.dsz = dsz; v.dstb = dstb; v.dwd = dwd;
    v.mr = mr; v.mrd = mrd;
    v.e_mv = e_mv; v.e_ma = e_ma; v.e_msz = e_msz; v.e_mstb = e_mstb; v.e_mwd = e_mwd;
    v.e_iok = e_iok; v.e_dok = e_dok;
    vecs.push_back(v);
  endfunction

  localparam logic [63:0] IA  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] FD  = 64'h0000_0013_0000_0093;
  localparam logic [63:0] SA  = 64'h0000_0000_8000_1008;
  localparam logic [63:0] IA2 = 64'h0000_0000_8000_0004;
  localparam logic [63:0] DA2 = 64'h0000_0000_8000_2000;

  // reference model state (transaction level)
  int          owner;      // 0 none, 1 fetch, 2 data
  logic [63:0] p_addr, p_wdata;
  logic [2:0]  p_size;
  logic [7:0]  p_stb;
  int          stall;
  logic        m_err;
  logic        last_was_d;

  // requester state for the random phase
  logic        r_iv, r_dv;
  logic [63:0] r_ia, r_da, r_dwd;
  logic [2:0]  r_dsz;
  logic [7:0]  r_dstb;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    #1;
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_size", bus.m_size, 0);
    chk("rst_m_strobe", bus.m_strobe, 0);
    chk("rst_m_wdata", bus.m_wdata, 0);
    chk("rst_i_ok", bus.i_data_ok, 0);
    chk("rst_d_ok", bus.d_data_ok, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // stray m_ready in idle
    add(0,0, 0,0,0,0,0, 1,64'hDEAD, 0,0,0,0,0, 0,0);
    add(0,0, 0,0,0,0,0, 1,64'hBEEF, 0,0,0,0,0, 0,0);
    // single fetch, m_ready 3 cycles after m_valid rises
    add(1,IA, 0,0,0,0,0, 0,0,  0,0,0,0,0, 0,0);
    add(1,IA, 0,0,0,0,0, 0,0,  1,IA,3,0,0, 0,0);
    add(1,IA, 0,0,0,0,0, 0,0,  1,IA,3,0,0, 0,0);
    add(1,IA, 0,0,0,0,0, 0,0,  1,IA,3,0,0, 0,0);
    add(1,IA, 0,0,0,0,0, 1,FD, 1,IA,3,0,0, 1,0);
    add(0,0,  0,0,0,0,0, 0,0,  0,0,0,0,0, 0,0);
    // byte store, immediate m_ready
    add(0,0, 1,SA,0,8'h01,64'hAB, 0,0,     0,0,0,0,0, 0,0);
    add(0,0, 1,SA,0,8'h01,64'hAB, 1,64'h55, 1,SA,0,8'h01,64'hAB, 0,1);
    add(0,0, 0,0,0,0,0,           0,0,     0,0,0,0,0, 0,0);
    // contention
`ifdef MEM_PORT_ARBITER_RR_EN
    add(1,IA2, 1,DA2,3,0,0, 0,0,        0,0,0,0,0, 0,0);
    add(1,IA2, 1,DA2,3,0,0, 1,64'h1111, 1,IA2,3,0,0, 1,0);
    add(0,0,   1,DA2,3,0,0, 0,0,        0,0,0,0,0, 0,0);
    add(0,0,   1,DA2,3,0,0, 1,64'h2222, 1,DA2,3,0,0, 0,1);
    add(0,0,   0,0,0,0,0,   0,0,        0,0,0,0,0, 0,0);
`else
    add(1,IA2, 1,DA2,3,0,0, 0,0,        0,0,0,0,0, 0,0);
    add(1,IA2, 1,DA2,3,0,0, 1,64'h1111, 1,DA2,3,0,0, 0,1);
    add(1,IA2, 0,0,0,0,0,   0,0,        0,0,0,0,0, 0,0);
    add(1,IA2, 0,0,0,0,0,   1,64'h2222, 1,IA2,3,0,0, 1,0);
    add(0,0,   0,0,0,0,0,   0,0,        0,0,0,0,0, 0,0);
`endif

    foreach (vecs[n]) begin
      @(negedge clk);
      drive(vecs[n].iv, vecs[n].ia, vecs[n].dv, vecs[n].da, vecs[n].dsz,
            vecs[n].dstb, vecs[n].dwd, vecs[n].mr, vecs[n].mrd);
      #1;
      chk($sformatf("vec%0d_m_valid", n), bus.m_valid, vecs[n].e_mv);
      chk($sformatf("vec%0d_busy", n), busy, vecs[n].e_mv);
      chk($sformatf("vec%0d_i_ok", n), bus.i_data_ok, vecs[n].e_iok);
      chk($sformatf("vec%0d_d_ok", n), bus.d_data_ok, vecs[n].e_dok);
      chk($sformatf("vec%0d_i_rdata", n), bus.i_rdata, vecs[n].e_iok ? vecs[n].mrd : 64'h0);
      chk($sformatf("vec%0d_d_rdata", n), bus.d_rdata, vecs[n].e_dok ? vecs[n].mrd : 64'h0);
      chk($sformatf("vec%0d_err", n), err, 0);
      if (vecs[n].e_mv) begin
        chk($sformatf("vec%0d_m_addr", n), bus.m_addr, vecs[n].e_ma);
        chk($sformatf("vec%0d_m_size", n), bus.m_size, vecs[n].e_msz);
        chk($sformatf("vec%0d_m_strobe", n), bus.m_strobe, vecs[n].e_mstb);
        chk($sformatf("vec%0d_m_wdata", n), bus.m_wdata, vecs[n].e_mwd);
      end
    end

    // reset in the middle of a data access
    @(negedge clk);
    drive(0, 0, 1, 64'h9000, 3'd2, 8'h0F, 64'h1234, 0, 0);
    #1 chk("mid_idle_m_valid", bus.m_valid, 0);
    @(negedge clk);
    #1 chk("mid_busy_m_valid", bus.m_valid, 1);
    bus.m_ready = 1'b1;
    bus.m_rdata = 64'h99;
    reset = 1'b1;
    #1;
    chk("mid_rst_m_valid", bus.m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_d_ok", bus.d_data_ok, 0);
    chk("mid_rst_d_rdata", bus.d_rdata, 0);
    chk("mid_rst_m_addr", bus.m_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 64'hA000, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("post_rst_idle", bus.m_valid, 0);
    @(negedge clk);
    bus.m_ready = 1'b1;
    bus.m_rdata = 64'h77;
    #1;
    chk("post_rst_m_valid", bus.m_valid, 1);
    chk("post_rst_m_addr", bus.m_addr, 64'hA000);
    chk("post_rst_i_ok", bus.i_data_ok, 1);
    chk("post_rst_i_rdata", bus.i_rdata, 64'h77);
    chk("post_rst_d_ok", bus.d_data_ok, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("post_rst_done", bus.m_valid, 0);

    // watchdog: 8 stalled busy cycles set err
    @(negedge clk);
    drive(1, 64'hB000, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("wd_start_err", err, 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("wd_c%0d_m_valid", k), bus.m_valid, 1);
      chk($sformatf("wd_c%0d_err", k), err, 0);
    end
    @(negedge clk);
    #1;
    chk("wd_c9_err", err, 1);
    chk("wd_c9_m_valid", bus.m_valid, 1);
    @(negedge clk);
    bus.m_ready = 1'b1;
    bus.m_rdata = 64'hCAFE;
    #1;
    chk("wd_ready_i_ok", bus.i_data_ok, 1);
    chk("wd_ready_i_rdata", bus.i_rdata, 64'hCAFE);
    chk("wd_ready_err", err, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("wd_after_m_valid", bus.m_valid, 0);
    chk("wd_after_err", err, 1);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("wd_rst_err", err, 0);
    @(negedge clk);
    reset = 1'b0;

    // random traffic against the reference model
    owner = 0; stall = 0; m_err = 1'b0; last_was_d = 1'b0;
    p_addr = 0; p_wdata = 0; p_size = 0; p_stb = 0;
    r_iv = 0; r_dv = 0; r_ia = 0; r_da = 0; r_dwd = 0; r_dsz = 0; r_dstb = 0;
    for (int c = 0; c < 3000; c++) begin
      logic        mr, e_iok, e_dok, take_d;
      logic [63:0] mrd;
      @(negedge clk);
      mr  = 1'($urandom_range(0, 1));
      mrd = {$urandom, $urandom};
      drive(r_iv, r_ia, r_dv, r_da, r_dsz, r_dstb, r_dwd, mr, mrd);
      #1;
      e_iok = (owner == 1) && mr;
      e_dok = (owner == 2) && mr;
      chk("rnd_m_valid", bus.m_valid, owner != 0);
      chk("rnd_busy", busy, owner != 0);
      chk("rnd_i_ok", bus.i_data_ok, e_iok);
      chk("rnd_d_ok", bus.d_data_ok, e_dok);
      chk("rnd_i_rdata", bus.i_rdata, e_iok ? mrd : 64'h0);
      chk("rnd_d_rdata", bus.d_rdata, e_dok ? mrd : 64'h0);
      chk("rnd_err", err, m_err);
      if (owner != 0) begin
        chk("rnd_m_addr", bus.m_addr, p_addr);
        chk("rnd_m_size", bus.m_size, p_size);
        chk("rnd_m_strobe", bus.m_strobe, p_stb);
        chk("rnd_m_wdata", bus.m_wdata, p_wdata);
      end

      // model advances across the coming clock edge
      if (owner == 0) begin
        take_d = r_dv;
`ifdef MEM_PORT_ARBITER_RR_EN
        if (r_dv && r_iv) take_d = !last_was_d;
`endif
        if (take_d) begin
          owner = 2; p_addr = r_da; p_size = r_dsz; p_stb = r_dstb; p_wdata = r_dwd;
          stall = 0; last_was_d = 1'b1;
        end else if (r_iv) begin
          owner = 1; p_addr = r_ia; p_size = 3'b011; p_stb = 8'h00; p_wdata = 64'h0;
          stall = 0; last_was_d = 1'b0;
        end
      end else if (mr) begin
        owner = 0;
      end else begin
        stall++;
        if (stall >= 8) m_err = 1'b1;
      end

      // requesters hold until their data_ok, then maybe issue again
      if (r_iv) begin
        if (e_iok) begin
          r_iv = 1'($urandom_range(0, 1));
          r_ia = {$urandom, $urandom};
        end
      end else if ($urandom_range(0, 3) == 0) begin
        r_iv = 1'b1;
        r_ia = {$urandom, $urandom};
      end
      if (r_dv) begin
        if (e_dok) begin
          r_dv   = 1'($urandom_range(0, 1));
          r_da   = {$urandom, $urandom};
          r_dsz  = 3'($urandom_range(0, 3));
          r_dstb = 8'($urandom);
          r_dwd  = {$urandom, $urandom};
        end
      end else if ($urandom_range(0, 3) == 0) begin
        r_dv   = 1'b1;
        r_da   = {$urandom, $urandom};
        r_dsz  = 3'($urandom_range(0, 3));
        r_dstb = 8'($urandom);
        r_dwd  = {$urandom, $urandom};
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single downstream memory port between instruction fetch (I side) and the memory stage (D side) of the 5-stage RV64 pipeline.
- Grants one requester at a time, holds the grant until the downstream access completes, then returns the response only to the granted side.
- Sits between the pipeline's fetch/memory stages and the memory/cache interface. Contains a watchdog for hung accesses.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width (word_t).
- TIMEOUT_CYCLES, 1024, busy cycles without m_ready before err sets; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_valid  in  1  fetch request valid; held with payload until i_data_ok
- i_addr  in  ADDR_W  fetch address (read only, size fixed to word)
- i_data_ok  out  1  fetch access complete; 1-cycle pulse
- i_rdata  out  DATA_W  fetch read data, valid with i_data_ok
- d_valid  in  1  data request valid; held with payload until d_data_ok
- d_addr  in  ADDR_W  data address
- d_size  in  3  access size (msize_t encoding)
- d_strobe  in  8  byte write strobes; all zero means load
- d_wdata  in  DATA_W  store data
- d_data_ok  out  1  data access complete; 1-cycle pulse
- d_rdata  out  DATA_W  load data, valid with d_data_ok
- m_valid  out  1  downstream request valid
- m_addr  out  ADDR_W  downstream address
- m_size  out  3  downstream size
- m_strobe  out  8  downstream strobes
- m_wdata  out  DATA_W  downstream store data
- m_ready  in  1  downstream access complete; m_rdata valid this cycle
- m_rdata  in  DATA_W  downstream read data
- busy  out  1  state != IDLE
- err  out  1  sticky watchdog flag

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. All transitions occur on the rising clk edge.
- Reset (asynchronous, any time, including mid-access):
  - state goes to IDLE; the in-flight access is abandoned.
  - All outputs are 0: m_valid, m_addr, m_size, m_strobe, m_wdata, i/d_data_ok, i/d_rdata, busy, err.
  - Watchdog counter clears.
- IDLE:
  - m_valid = 0.
  - If d_valid: go to BUSY_D, latching d_addr, d_size, d_strobe, d_wdata into the m_* registers.
  - Else if i_valid: go to BUSY_I, latching i_addr; m_size = word (3'b011), m_strobe = 0, m_wdata = 0.
  - Default priority is fixed, D over I (the older instruction wins).
- BUSY_x:
  - m_valid = 1 and the m_* payload is held stable.
  - On m_ready: x_data_ok = 1 and x_rdata = m_rdata in the same cycle (combinational pass-through); next state is IDLE.
  - The other side's data_ok stays 0.
- Latency:
  - Request sampled in IDLE at cycle 0; m_valid high from cycle 1.
  - m_ready at cycle k gives data_ok at cycle k, and m_valid is low at cycle k+1.
  - Minimum one idle bubble between accesses; best-case occupancy is 2 cycles per access.
- Simultaneous events:
  - d_valid and i_valid both high in IDLE: D is granted; I waits.
  - A requester rising while the other side is BUSY: it waits; no preemption.
  - m_ready while in IDLE: ignored, no data_ok issued.
- Requester rule: a requester deasserting valid before its data_ok is a protocol violation. The arbiter completes the latched access regardless and still pulses data_ok.
- i_rdata / d_rdata are 0 when the corresponding data_ok is 0.
- Watchdog:
  - Counter clears on entry to BUSY and counts each BUSY cycle without m_ready.
  - When it reaches TIMEOUT_CYCLES, err sets and stays set until reset.
  - State is unaffected; the arbiter keeps waiting for m_ready.
  - Counter saturates; it never wraps.
- busy = 1 in BUSY_I and BUSY_D.

Optional Feature:
- Macro: MEM_PORT_ARBITER_RR_EN.
- Defined:
  - A 1-bit last_grant register (reset value I) records the side granted at each IDLE→BUSY transition.
  - When both valid in IDLE, grant the side opposite last_grant; a single requester is always granted.
- Undefined:
  - Fixed D-over-I priority; last_grant is not implemented.

Test Plan:
- Single fetch:
  - Stimulus: i_valid=1, i_addr=0x8000_0000; m_ready asserted 3 cycles after m_valid rises, m_rdata=0x0000_0013_0000_0093.
  - Required: m_valid from cycle 1, m_size=3, m_strobe=0; i_data_ok pulse with that data; d_data_ok stays 0.
- Store:
  - Stimulus: d_valid, d_addr=0x8000_1008, d_size=byte, d_strobe=0x01, d_wdata=0xAB; m_ready immediate.
  - Required: m_* match the request; d_data_ok on the cycle m_valid is first seen with m_ready; next cycle m_valid=0.
- Contention:
  - Stimulus: i_valid and d_valid rise together.
  - Required: D served first, then I after one IDLE bubble.
  - With MEM_PORT_ARBITER_RR_EN and last_grant=D: I is served first.
- Reset mid-access:
  - Stimulus: assert reset while in BUSY_D, before m_ready.
  - Required: m_valid, busy and data_ok all 0 immediately (asynchronous); after release, IDLE, and a new request is served normally.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=8, m_ready held 0.
  - Required: err=1 after the 8th busy cycle; stays 1 after a later m_ready; data_ok still pulses on that m_ready.
- Stray m_ready:
  - Stimulus: m_ready=1 while IDLE with no requests.
  - Required: no data_ok pulse, state stays IDLE.
